alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_if.sv | 36 +++
 rtl/alu_issue.sv | 138 +++++++++++++
 tb/tb_alu_issue.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_if
// Description : Issue-side and ALU-side handshake bundle for alu_issue.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [5:0]  in_funct;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_src1;
    logic [31:0] out_src2;
    logic [3:0]  out_ALU_control;
    logic [2:0]  out_bonus_control;
    logic        out_illegal;
    logic [7:0]  illegal_count;

    modport master (
        output in_valid, in_opcode, in_funct, in_rs_data, in_rt_data, in_imm, out_ready,
        input  in_ready, out_valid, out_src1, out_src2, out_ALU_control,
               out_bonus_control, out_illegal, illegal_count
    );

    modport slave (
        input  in_valid, in_opcode, in_funct, in_rs_data, in_rt_data, in_imm, out_ready,
        output in_ready, out_valid, out_src1, out_src2, out_ALU_control,
               out_bonus_control, out_illegal, illegal_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Decodes MIPS-style ALU instructions into operands/controls and
//               buffers them in a small FIFO toward the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue #(
    parameter int DEPTH = 2
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    alu_issue_if.slave  bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [3:0]  alu;
        logic [2:0]  bonus;
        logic        illegal;
    } entry_t;

    entry_t               r_mem [DEPTH];
    entry_t               r_last;
    entry_t               w_dec;
    entry_t               w_head;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic [7:0]           r_ill_cnt;
    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_push;
    logic                 w_pop;
    logic [31:0]          w_imm_sx;
    logic [31:0]          w_imm_zx;

    assign w_in_ready  = (r_count != c_FULL);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_imm_sx    = {{16{bus.in_imm[15]}}, bus.in_imm};
    assign w_imm_zx    = {16'h0000, bus.in_imm};

    always_comb begin
        w_dec.src1    = bus.in_rs_data;
        w_dec.src2    = bus.in_rt_data;
        w_dec.alu     = 4'b0000;
        w_dec.bonus   = 3'b000;
        w_dec.illegal = 1'b0;
        if (bus.in_opcode == 6'h00) begin
            case (bus.in_funct)
                6'h24:   w_dec.alu = 4'b0000;
                6'h25:   w_dec.alu = 4'b0001;
                6'h20:   w_dec.alu = 4'b0010;
                6'h22:   w_dec.alu = 4'b0110;
                6'h27:   w_dec.alu = 4'b1100;
                6'h2A:   w_dec.alu = 4'b0111;
                6'h2B: begin
                    w_dec.alu   = 4'b0111;
                    w_dec.bonus = 3'b101;
                end
                default: w_dec.illegal = 1'b1;
            endcase
        end else begin
            case (bus.in_opcode)
                6'h08: begin
                    w_dec.alu  = 4'b0010;
                    w_dec.src2 = w_imm_sx;
                end
                6'h0A: begin
                    w_dec.alu  = 4'b0111;
                    w_dec.src2 = w_imm_sx;
                end
                6'h0B: begin
                    w_dec.alu   = 4'b0111;
                    w_dec.bonus = 3'b101;
                    w_dec.src2  = w_imm_sx;
                end
                6'h0C: begin
                    w_dec.alu  = 4'b0000;
                    w_dec.src2 = w_imm_zx;
                end
                6'h0D: begin
                    w_dec.alu  = 4'b0001;
                    w_dec.src2 = w_imm_zx;
                end
                default: w_dec.illegal = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ill_cnt <= 8'h00;
            r_last    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_dec;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                if (w_dec.illegal && (r_ill_cnt != 8'hFF)) begin
                    r_ill_cnt <= r_ill_cnt + 8'h01;
                end
            end
            // Remember the departing head so outputs hold it once the queue drains.
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head = w_out_valid ? r_mem[r_rd_ptr] : r_last;

    assign bus.in_ready          = w_in_ready;
    assign bus.out_valid         = w_out_valid;
    assign bus.out_src1          = w_head.src1;
    assign bus.out_src2          = w_head.src2;
    assign bus.out_ALU_control   = w_head.alu;
    assign bus.out_bonus_control = w_head.bonus;
    assign bus.out_illegal       = w_head.illegal;
    assign bus.illegal_count     = r_ill_cnt;
endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue
// Description : Randomized scoreboard bench for alu_issue against a table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_if bus ();

    alu_issue #(.DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [3:0]  alu;
        logic [2:0]  bon;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   vectors   = 0;
    int   errors    = 0;
    int   model_ill = 0;
    int   rdy_mode  = 2;  // 0 random, 1 always ready, 2 never ready

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [15:0] imm);
        exp_t e;
        e.s1 = rs; e.s2 = rt; e.alu = 4'd0; e.bon = 3'd0; e.ill = 1'b0;
        if (op == 6'h00) begin
            if      (fn == 6'h24) e.alu = 4'd0;
            else if (fn == 6'h25) e.alu = 4'd1;
            else if (fn == 6'h20) e.alu = 4'd2;
            else if (fn == 6'h22) e.alu = 4'd6;
            else if (fn == 6'h27) e.alu = 4'd12;
            else if (fn == 6'h2A) e.alu = 4'd7;
            else if (fn == 6'h2B) begin e.alu = 4'd7; e.bon = 3'd5; end
            else e.ill = 1'b1;
        end else if (op == 6'h08) begin e.alu = 4'd2; e.s2 = 32'($signed(imm)); end
        else if (op == 6'h0A) begin e.alu = 4'd7; e.s2 = 32'($signed(imm)); end
        else if (op == 6'h0B) begin e.alu = 4'd7; e.bon = 3'd5; e.s2 = 32'($signed(imm)); end
        else if (op == 6'h0C) begin e.alu = 4'd0; e.s2 = 32'(imm); end
        else if (op == 6'h0D) begin e.alu = 4'd1; e.s2 = 32'(imm); end
        else e.ill = 1'b1;
        return e;
    endfunction

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [15:0] imm);
        exp_t e;
        int   n = 0;
        bit   ok = 1'b0;
        bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_funct = fn;
        bus.in_rs_data = rs; bus.in_rt_data = rt; bus.in_imm = imm;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            n++;
        end
        if (!ok) chk("accept_timeout", 80'(n), 80'(0));
        @(posedge clk);
        if (ok) begin
            e = model(op, fn, rs, rt, imm);
            sb.push_back(e);
            if (e.ill && model_ill < 255) model_ill++;
        end
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_opcode = 6'h3F; bus.in_funct = 6'h00;
        @(posedge clk);
        sb.delete();
        model_ill = 0;
        #1 rst = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'($urandom_range(0, 1));
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: the queue mirrors registered occupancy; compare the head every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("in_ready", 80'(bus.in_ready), 80'(sb.size() < DEPTH));
                chk("out_valid", 80'(bus.out_valid), 80'(sb.size() != 0));
                chk("illegal_count", 80'(bus.illegal_count), 80'(model_ill));
                if (bus.out_valid && sb.size() != 0) begin
                    e = sb[0];
                    chk("head", {bus.out_src1, bus.out_src2, bus.out_ALU_control,
                                 bus.out_bonus_control, bus.out_illegal, 8'h00},
                        {e.s1, e.s2, e.alu, e.bon, e.ill, 8'h00});
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [5:0] ops [5] = '{6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D};
        logic [5:0] fns [7] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h27, 6'h2A, 6'h2B};
        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_funct = '0;
        bus.in_rs_data = '0; bus.in_rt_data = '0; bus.in_imm = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {bus.out_src1, bus.out_src2, bus.out_ALU_control,
                              bus.out_bonus_control, bus.out_illegal, bus.out_valid,
                              bus.in_ready, bus.illegal_count[5:0]},
            {32'd0, 32'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 6'd0});
        @(posedge clk); #1;

        rdy_mode = 1;
        issue(6'h00, 6'h20, 32'd5, 32'd7, 16'h0);
        issue(6'h0A, 6'h00, 32'd3, 32'd0, 16'hFFFF);
        issue(6'h0D, 6'h00, 32'd9, 32'd0, 16'h8000);

        // Fill with the ALU stalled, hold a third, then release.
        @(negedge clk); rdy_mode = 2;
        @(posedge clk); #1;
        issue(6'h00, 6'h22, 32'd100, 32'd1, 16'h0);
        issue(6'h00, 6'h2B, 32'd2, 32'hFFFF_FFFF, 16'h0);
        fork
            issue(6'h0C, 6'h00, 32'hDEAD_BEEF, 32'd0, 16'hF00F);
            begin
                repeat (4) @(negedge clk);
                rdy_mode = 1;
            end
        join

        @(negedge clk); rdy_mode = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 13);
            if (k < 7)
                issue(6'h00, fns[k], $urandom, $urandom, 16'($urandom));
            else if (k < 12)
                issue(ops[k-7], 6'($urandom), $urandom, $urandom, 16'($urandom));
            else if (k == 12)
                issue(6'h00, 6'($urandom), $urandom, $urandom, 16'($urandom));
            else
                issue(6'($urandom), 6'($urandom), $urandom, $urandom, 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        @(negedge clk); rdy_mode = 1;
        repeat (4) @(posedge clk);
        #1 do_reset();
        for (int i = 0; i < 300; i++)
            issue(6'h3F, 6'($urandom), $urandom, $urandom, 16'($urandom));
        @(negedge clk);
        chk("illegal_count_sat", 80'(bus.illegal_count), 80'(255));

        // Reset with two entries queued; the accept offered during reset is dropped.
        rdy_mode = 2;
        @(posedge clk); #1;
        issue(6'h00, 6'h20, 32'd1, 32'd2, 16'h0);
        issue(6'h3F, 6'h00, 32'd3, 32'd4, 16'h0);
        do_reset();
        @(negedge clk);
        chk("post_reset", {bus.out_valid, bus.in_ready, bus.illegal_count},
            {1'b0, 1'b1, 8'd0});

        rdy_mode = 1;
        @(posedge clk); #1;
        issue(6'h00, 6'h27, 32'h0F0F_0F0F, 32'h00FF_00FF, 16'h0);
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) chk("drain_timeout", 80'(sb.size()), 80'(0));
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire
